// File: rtl/ram_access_unit.sv
// ram_access_unit
// ---------------
// Load/store front end between a RISC-V memory stage and a word-addressed RAM
// whose read port is combinational. Byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW
// requests become word accesses. Sub-word stores use a read-modify-write
// sequence. Misaligned, out-of-range and illegal-funct3 requests are rejected
// without any RAM access.
//
// Ports:
//   clk, resetN              clock (rising edge), async active-low reset
//   reqValid / reqReady      request handshake (accepted when both are high)
//   reqStore, reqFunct3      store flag and RISC-V funct3 (size / signedness)
//   reqAddr, reqWData        byte address and store data
//   respValid                one-cycle completion pulse
//   respData, respError      load result (0 for stores/errors), reject flag
//   ramAddress, ramDataIn    word index and write data towards the RAM
//   ramWriteEnable           single-cycle write strobe
//   ramDataOut               combinational read data from the RAM
module ram_access_unit #(
  parameter int Height = 256,
  parameter int Length = 32,
  localparam int AW = $clog2(Height)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqStore,
  input  logic [2:0]        reqFunct3,
  input  logic [31:0]       reqAddr,
  input  logic [Length-1:0] reqWData,
  output logic              respValid,
  output logic [Length-1:0] respData,
  output logic              respError,
  output logic [AW-1:0]     ramAddress,
  output logic [Length-1:0] ramDataIn,
  output logic              ramWriteEnable,
  input  logic [Length-1:0] ramDataOut
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [29:0] HEIGHT_WORDS = 30'(Height);

  state_t      state_reg;
  logic        store_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;   // byte offset within the word
  logic [15:0] wdata_reg;    // only the low half is needed for SB/SH merges

  logic illegal_next;
  logic misaligned_next;
  logic out_of_range_next;
  logic error_next;

  // Classification of the request currently offered on the request port.
  always_comb begin
    illegal_next = 1'b1;
    if (reqStore) begin
      case (reqFunct3)
        3'b000, 3'b001, 3'b010: illegal_next = 1'b0;
        default:                illegal_next = 1'b1;
      endcase
    end else begin
      case (reqFunct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_next = 1'b0;
        default:                                illegal_next = 1'b1;
      endcase
    end
    misaligned_next   = ((reqFunct3[1:0] == 2'b01) && reqAddr[0]) ||
                        ((reqFunct3[1:0] == 2'b10) && (reqAddr[1:0] != 2'b00));
    out_of_range_next = (reqAddr[31:2] >= HEIGHT_WORDS);
    error_next        = illegal_next || misaligned_next || out_of_range_next;
  end

  // Select the addressed byte/halfword and extend it according to funct3.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_extract = {24'h0, shifted[7:0]};
      3'b001:  load_extract = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_extract = {16'h0, shifted[15:0]};
      default: load_extract = word;
    endcase
  endfunction

  // Replace one byte or halfword lane of the old word (little-endian lanes).
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic        is_half,
                                              input logic [1:0]  off,
                                              input logic [15:0] wd);
    logic [31:0] mask;
    logic [31:0] data;
    if (is_half) begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      data = {16'h0, wd} << {off[1], 4'b0000};
    end else begin
      mask = 32'h0000_00FF << {off, 3'b000};
      data = {24'h0, wd[7:0]} << {off, 3'b000};
    end
    store_merge = (old_word & ~mask) | (data & mask);
  endfunction

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      store_reg      <= 1'b0;
      funct3_reg     <= 3'b000;
      offset_reg     <= 2'b00;
      wdata_reg      <= 16'h0;
      reqReady       <= 1'b1;
      respValid      <= 1'b0;
      respData       <= '0;
      respError      <= 1'b0;
      ramAddress     <= '0;
      ramDataIn      <= '0;
      ramWriteEnable <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on the transition that needs them.
      respValid      <= 1'b0;
      ramWriteEnable <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (reqValid) begin
            store_reg  <= reqStore;
            funct3_reg <= reqFunct3;
            offset_reg <= reqAddr[1:0];
            wdata_reg  <= reqWData[15:0];
            reqReady   <= 1'b0;
            if (error_next) begin
              state_reg <= DONE;
              respValid <= 1'b1;
              respError <= 1'b1;
              respData  <= '0;
            end else begin
              ramAddress <= reqAddr[AW+1:2];
              if (reqStore && (reqFunct3[1:0] == 2'b10)) begin
                // Full-word store needs no read: go straight to the write cycle.
                state_reg      <= WRITE;
                ramDataIn      <= reqWData;
                ramWriteEnable <= 1'b1;
              end else begin
                state_reg <= READ;
              end
            end
          end
        end
        READ: begin
          if (!store_reg) begin
            state_reg <= DONE;
            respValid <= 1'b1;
            respError <= 1'b0;
            respData  <= load_extract(ramDataOut, funct3_reg, offset_reg);
          end else begin
            // The old word is merged as it is read, so the write cycle only
            // has to present the prepared word.
            state_reg      <= WRITE;
            ramDataIn      <= store_merge(ramDataOut, funct3_reg[0], offset_reg, wdata_reg);
            ramWriteEnable <= 1'b1;
          end
        end
        WRITE: begin
          state_reg <= DONE;
          respValid <= 1'b1;
          respError <= 1'b0;
          respData  <= '0;
        end
        DONE: begin
          state_reg <= IDLE;
          reqReady  <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          reqReady  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Testbench for ram_access_unit: directed requests with hand-computed results,
// checked by a scoreboard monitor that pops expectations on each respValid.
module tb_ram_access_unit;

  localparam int HEIGHT = 256;
  localparam int AW = $clog2(HEIGHT);

  logic          clk;
  logic          resetN;
  logic          reqValid;
  logic          reqReady;
  logic          reqStore;
  logic [2:0]    reqFunct3;
  logic [31:0]   reqAddr;
  logic [31:0]   reqWData;
  logic          respValid;
  logic [31:0]   respData;
  logic          respError;
  logic [AW-1:0] ramAddress;
  logic [31:0]   ramDataIn;
  logic          ramWriteEnable;
  logic [31:0]   ramDataOut;

  ram_access_unit #(.Height(HEIGHT), .Length(32)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqStore       (reqStore),
    .reqFunct3      (reqFunct3),
    .reqAddr        (reqAddr),
    .reqWData       (reqWData),
    .respValid      (respValid),
    .respData       (respData),
    .respError      (respError),
    .ramAddress     (ramAddress),
    .ramDataIn      (ramDataIn),
    .ramWriteEnable (ramWriteEnable),
    .ramDataOut     (ramDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, synchronous write. The bench can
  // preload words through the poke port.
  logic [31:0] mem [HEIGHT] = '{default: 32'h0};
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'h0;
  logic [31:0] poke_data = 32'h0;
  int          cyc = 0;
  int          wr_count = 0;

  assign ramDataOut = mem[ramAddress];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (resetN && ramWriteEnable) begin
      mem[ramAddress] <= ramDataIn;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          writes;
    int          gap;
    int          acc_cyc;
    int          acc_wr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_resp_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetN && respValid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got respValid data=0x%08h err=%0b, expected none",
                   respData, respError);
        end else begin
          e = sb_q.pop_front();
          $display("resp  cyc=%0d data=0x%08h err=%0b latency=%0d", cyc, respData,
                   respError, cyc - e.acc_cyc);
          check("resp_data", respData, e.data);
          check("resp_error", {31'b0, respError}, {31'b0, e.err});
          check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          check("write_strobes", 32'(wr_count - e.acc_wr), 32'(e.writes));
          if (e.gap != 0) check("resp_gap", 32'(cyc - last_resp_cyc), 32'(e.gap));
        end
        last_resp_cyc = cyc;
      end
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Waits (bounded) for reqReady, presents the request, records the expected
  // response, and returns 1 time unit after the accepting edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err,
                       input int lat, input int writes, input int gap,
                       input bit keep, input bit track);
    exp_t e;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!reqReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!reqReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got reqReady=0 for 20 cycles, expected 1");
      return;
    end
    reqStore  = st;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWData  = wd;
    reqValid  = 1'b1;
    e.data = exp_data; e.err = exp_err; e.lat = lat; e.writes = writes;
    e.gap = gap; e.acc_cyc = cyc; e.acc_wr = wr_count;
    if (track) sb_q.push_back(e);
    $display("issue cyc=%0d store=%0b f3=%03b addr=0x%08h wdata=0x%08h", cyc, st, f3, addr, wd);
    @(posedge clk);
    #1;
    if (!keep) reqValid = 1'b0;
  endtask

  initial begin
    int waited;
    resetN = 1'b0; reqValid = 1'b0; reqStore = 1'b0;
    reqFunct3 = 3'b000; reqAddr = 32'h0; reqWData = 32'h0;
    fork
      monitor_loop();
    join_none

    poke(8'd3, 32'h8899AABB);
    @(posedge clk);
    #1;
    check("rst_reqReady", {31'b0, reqReady}, 32'd1);
    check("rst_respValid", {31'b0, respValid}, 32'd0);
    check("rst_respData", respData, 32'h0);
    check("rst_respError", {31'b0, respError}, 32'd0);
    check("rst_ramAddress", 32'(ramAddress), 32'h0);
    check("rst_ramDataIn", ramDataIn, 32'h0);
    check("rst_ramWriteEnable", {31'b0, ramWriteEnable}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Loads from word 3 = 0x8899AABB
    issue(0, 3'b000, 32'h0D, 32'h0, 32'hFFFFFFAA, 0, 2, 0, 0, 0, 1);
    issue(0, 3'b100, 32'h0D, 32'h0, 32'h000000AA, 0, 2, 0, 0, 0, 1);
    issue(0, 3'b001, 32'h0E, 32'h0, 32'hFFFF8899, 0, 2, 0, 0, 0, 1);
    issue(0, 3'b010, 32'h0C, 32'h0, 32'h8899AABB, 0, 2, 0, 0, 0, 1);
    issue(0, 3'b010, 32'h3FC, 32'h0, 32'h00000000, 0, 2, 0, 0, 0, 1);  // last word in range

    // Byte store via read-modify-write
    issue(1, 3'b000, 32'h0E, 32'h12345677, 32'h0, 0, 3, 1, 0, 0, 1);
    issue(0, 3'b010, 32'h0C, 32'h0, 32'h8877AABB, 0, 2, 0, 0, 0, 1);

    // Halfword and word stores from a fresh word 3
    poke(8'd3, 32'h8899AABB);
    issue(1, 3'b001, 32'h0C, 32'hCAFEBEEF, 32'h0, 0, 3, 1, 0, 0, 1);
    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 0, 0, 1);
    issue(0, 3'b010, 32'h0C, 32'h0, 32'h8899BEEF, 0, 2, 0, 0, 0, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0, 0, 1);
    issue(0, 3'b101, 32'h0E, 32'h0, 32'h00008899, 0, 2, 0, 0, 0, 1);
    issue(0, 3'b001, 32'h0C, 32'h0, 32'hFFFFBEEF, 0, 2, 0, 0, 0, 1);

    // Rejected requests
    issue(0, 3'b010, 32'h0E, 32'h0, 32'h0, 1, 1, 0, 0, 0, 1);         // misaligned LW
    issue(1, 3'b001, 32'h0D, 32'h5555AAAA, 32'h0, 1, 1, 0, 0, 0, 1);  // misaligned SH
    issue(0, 3'b010, 32'h400, 32'h0, 32'h0, 1, 1, 0, 0, 0, 1);        // out of range
    issue(0, 3'b011, 32'h0C, 32'h0, 32'h0, 1, 1, 0, 0, 0, 1);         // illegal load funct3
    issue(1, 3'b100, 32'h0C, 32'h11111111, 32'h0, 1, 1, 0, 0, 0, 1);  // illegal store funct3
    issue(1, 3'b010, 32'h400, 32'h22222222, 32'h0, 1, 1, 0, 0, 0, 1); // out-of-range SW
    repeat (3) @(negedge clk);
    check("ram_w3_after_errors", mem[3], 32'h8899BEEF);
    check("ram_w4_after_errors", mem[4], 32'hDEADBEEF);

    // reqValid held high across three loads
    issue(0, 3'b010, 32'h0C, 32'h0, 32'h8899BEEF, 0, 2, 0, 0, 1, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 3, 1, 1);
    issue(0, 3'b010, 32'h0C, 32'h0, 32'h8899BEEF, 0, 2, 0, 3, 0, 1);

    // Reset during the write cycle of a byte store
    issue(1, 3'b000, 32'h0C, 32'h000000FF, 32'h0, 0, 3, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check("sb_in_write_we", {31'b0, ramWriteEnable}, 32'd1);
    resetN = 1'b0;
    #1;
    check("midrst_reqReady", {31'b0, reqReady}, 32'd1);
    check("midrst_respValid", {31'b0, respValid}, 32'd0);
    check("midrst_ramWriteEnable", {31'b0, ramWriteEnable}, 32'd0);
    check("midrst_ramDataIn", ramDataIn, 32'h0);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    issue(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0, 0, 1);

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_access_unit.md
# ram_access_unit

Load/store front end between the RISC-V core's memory stage and the word-addressed, combinational-read RAM. Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests, converts them to word accesses, and performs read-modify-write for sub-word stores. Returns sign- or zero-extended load data. Flags misaligned, out-of-range or illegal requests without touching memory.

## Interface
- Height, 256: RAM depth in words; word index width AW = $clog2(Height).
- Length, 32: data width in bits; fixed at 32 for this block.
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present; sampled only when reqReady=1.
- reqReady  out  1  unit is idle and can accept a request.
- reqStore  in  1  1 = store, 0 = load.
- reqFunct3  in  3  RISC-V funct3 giving access size and signedness.
- reqAddr  in  32  byte address.
- reqWData  in  32  store data; the low bytes are used for SB/SH.
- respValid  out  1  one-cycle pulse; the request has completed.
- respData  out  32  load result; 0 for stores and errors.
- respError  out  1  valid with respValid; the request was rejected.
- ramAddress  out  AW  word index into the RAM.
- ramDataIn  out  32  word to write.
- ramWriteEnable  out  1  write strobe.
- ramDataOut  in  32  combinational read data from the RAM.

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Reset enters IDLE.
- Reset values: reqReady=1, respValid=0, respData=0, respError=0, ramAddress=0, ramDataIn=0, ramWriteEnable=0. All captured request registers are cleared.
- IDLE: reqReady=1. When reqValid=1, capture reqStore, reqFunct3, reqAddr and reqWData, then classify the request:
  - Error cases:
    - illegal funct3: load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010};
    - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0;
    - out of range: addr[31:2] >= Height.
  - Any error -> DONE with respError=1. The RAM is never written.
  - Load -> READ. Store word -> WRITE. Store byte or halfword -> READ.
- READ: ramAddress = addr[AW+1:2], ramWriteEnable=0. Latch ramDataOut into oldWord at the clock edge. A load goes to DONE; a sub-word store goes to WRITE.
- WRITE: ramAddress held. ramDataIn is:
  - SW: the full reqWData;
  - SH: oldWord with halfword lane addr[1] replaced by reqWData[15:0];
  - SB: oldWord with byte lane addr[1:0] replaced by reqWData[7:0].
  - Lanes are little-endian: byte 0 = bits[7:0].
  - ramWriteEnable=1 for exactly this one cycle. Next state is DONE.
- DONE: respValid=1 for one cycle, then IDLE. respData for loads is:
  - LB/LBU: the selected byte, sign- or zero-extended;
  - LH/LHU: the selected halfword, sign- or zero-extended;
  - LW: the whole word.
- ramWriteEnable is 0 in every state except WRITE. ramDataIn and ramAddress hold their last values outside active states.
- reqReady=0 in READ, WRITE and DONE. reqValid is ignored there; there is no queueing.

## Timing
- The accepting edge is the first rising clk edge with reqReady=1 and reqValid=1.
- respValid asserts in the cycle after:
  - error: 1 edge after accept;
  - LW/LH/LB/LHU/LBU: 2 edges after accept;
  - SW: 2 edges after accept;
  - SB/SH: 3 edges after accept.
- reqReady returns to 1 in the cycle after respValid. Back-to-back throughput is therefore one request per (latency+1) cycles.
- respData and respError are registered. They are valid only while respValid=1 and hold until the next DONE.
- A read-after-write to the same word, issued on the next accept, sees the new data. The write completes before reqReady re-asserts.
- Reset mid-operation (in READ or WRITE): all outputs go to reset values immediately. A WRITE cut by reset may or may not have updated the RAM; no respValid is produced.

## Test plan
- RAM word 3 = 0x8899AABB. LB at addr 0x0D -> respData=0xFFFFFFAA. LBU at addr 0x0D -> 0x000000AA. LH at addr 0x0E -> 0xFFFF8899. LW at addr 0x0C -> 0x8899AABB. Each has respValid 2 edges after accept and respError=0.
- SB at 0x0E with reqWData=0x12345677, then LW at 0x0C -> 0x8877AABB. Exactly one ramWriteEnable cycle; respValid 3 edges after accept.
- SH at 0x0C with 0xCAFEBEEF, then SW at 0x10 with 0xDEADBEEF, then LW at 0x0C and LW at 0x10 -> 0x8899BEEF and 0xDEADBEEF.
- Error cases, each asserting respError=1 with respValid 1 edge after accept, ramWriteEnable never high and RAM unchanged:
  - LW at 0x0E (misaligned);
  - SH at 0x0D (misaligned);
  - LW at 0x400 with Height=256 (out of range);
  - load with funct3=011 (illegal).
- reqValid held high across 3 LW requests: each accepted only when reqReady=1. Three respValid pulses, spaced 3 cycles apart.
- Assert resetN=0 during the WRITE of an SB: reqReady=1, respValid=0, ramWriteEnable=0 immediately. After release, the next LW completes normally.
